// File: rtl/gray_conv_scheduler.sv
// Round-robin scheduler sharing one binary/Gray conversion engine
// between R requesters; Gray->binary resolves one bit per cycle.
module gray_conv_scheduler #(
  parameter int N = 4,
  parameter int R = 4,
  localparam int IW = $clog2(R)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [R-1:0]   req,
  input  logic [R-1:0]   mode,
  input  logic [R*N-1:0] data_in,
  output logic [R-1:0]   gnt,
  output logic [R-1:0]   done,
  output logic [N-1:0]   result,
  output logic [IW-1:0]  result_id,
  output logic          busy
);

  localparam int CW = $clog2(N);

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [R-1:0]  r_gnt;
  logic [R-1:0]  r_done;
  logic [N-1:0]  r_result;
  logic [IW-1:0] r_result_id;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_id;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_op;
  logic [N-1:0]  r_w;
  logic          r_mode;

  logic [R-1:0]  w_gnt_nxt;
  logic [R-1:0]  w_done_nxt;
  logic          w_cap;
  logic          w_fin;
  logic          w_found;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_cand;
  logic [N-1:0]  w_op_sel;
  logic [N-1:0]  w_w_nxt;
  logic [N-1:0]  w_res;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_cand  = r_last;
    for (int k = 1; k <= R; k++) begin
      w_cand = r_last + IW'(k);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_op_sel = data_in[int'(w_win)*N +: N];

  // Bit i of the binary value is resolved when cnt reaches N-2-i.
  always_comb begin
    w_w_nxt = r_w;
    for (int i = 0; i < N-1; i++) begin
      if (r_cnt == CW'(N-2-i)) begin
        w_w_nxt[i] = r_w[i+1] ^ r_op[i];
      end
    end
  end

  assign w_res = r_mode ? w_w_nxt : (r_op ^ (r_op >> 1));

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = '0;
    w_done_nxt  = '0;
    w_cap       = 1'b0;
    w_fin       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt      = S_CONV;
          w_gnt_nxt[w_win] = 1'b1;
          w_cap            = 1'b1;
        end
      end
      S_CONV: begin
        if (!r_mode || (r_cnt == CW'(N-2))) begin
          w_state_nxt      = S_IDLE;
          w_done_nxt[r_id] = 1'b1;
          w_fin            = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_result    <= '0;
      r_result_id <= '0;
      r_last      <= IW'(R-1);
      r_id        <= '0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_w         <= '0;
      r_mode      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      if (w_cap) begin
        r_last <= w_win;
        r_id   <= w_win;
        r_op   <= w_op_sel;
        r_mode <= mode[w_win];
        r_cnt  <= '0;
        r_w    <= {w_op_sel[N-1], {(N-1){1'b0}}};
      end else if (r_state == S_CONV) begin
        r_cnt <= r_cnt + CW'(1);
        r_w   <= w_w_nxt;
      end
      if (w_fin) begin
        r_result    <= w_res;
        r_result_id <= r_id;
      end
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign result    = r_result;
  assign result_id = r_result_id;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Scoreboard bench for gray_conv_scheduler (N=4, R=4).
// Grants and results are queued at drive time and popped on output.
module tb_gray_conv_scheduler;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [N-1:0]  res;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [R-1:0]   req;
  logic [R-1:0]   mode;
  logic [R*N-1:0] data_in;
  logic [R-1:0]   gnt;
  logic [R-1:0]   done;
  logic [N-1:0]   result;
  logic [IW-1:0]  result_id;
  logic          busy;

  exp_t sb_q[$];
  int   gq[$];
  int   errors = 0;
  int   checks = 0;

  gray_conv_scheduler #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mode      (mode),
    .data_in   (data_in),
    .gnt       (gnt),
    .done      (done),
    .result    (result),
    .result_id (result_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got,
                     input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] b2g(input logic [N-1:0] v);
    return v ^ (v >> 1);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != '0) begin
        chk("gnt_onehot", $countones(gnt), 1);
        if (gq.size() == 0) chk("gnt_unexp", gnt, 0);
        else chk("gnt_id", gnt, 1 << gq.pop_front());
      end
      if (done != '0) begin
        chk("gnt_done_overlap", gnt & done, 0);
        chk("busy_at_done", busy, 0);
        if (sb_q.size() == 0) chk("done_unexp", done, 0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("done_id", done, 1 << e.id);
          chk("result", result, e.res);
          chk("result_id", result_id, e.id);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic do_req(input int id, input logic m,
                        input logic [N-1:0] d,
                        input logic [N-1:0] exp_res, input int lat);
    exp_t e;
    int n;
    bit ok;
    req[id] = 1'b1;
    mode[id] = m;
    data_in[id*N +: N] = d;
    e.id = IW'(id);
    e.res = exp_res;
    sb_q.push_back(e);
    gq.push_back(id);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt[id]) begin ok = 1; break; end
    end
    if (!ok) begin chk("gnt_timeout", 0, 1); req[id] = 1'b0; return; end
    chk("busy_at_gnt", busy, 1);
    req[id] = 1'b0;
    n = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (done[id]) begin ok = 1; break; end
    end
    if (!ok) chk("done_timeout", 0, 1);
    else chk("latency", n, lat);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0 && gq.size() == 0) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("drain_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] g;
    exp_t e;
    int ng;
    bit ok;
    req = '0;
    mode = '0;
    data_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_result_id", result_id, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness: all four requesting continuously.
    req = 4'hF;
    mode = 4'h0;
    for (int k = 0; k < R; k++) data_in[k*N +: N] = N'(k);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < R; k++) begin
        gq.push_back(k);
        e.id = IW'(k);
        e.res = b2g(N'(k));
        sb_q.push_back(e);
      end
    end
    ng = 0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt != '0) ng++;
      if (ng == 8) begin ok = 1; break; end
    end
    req = '0;
    if (!ok) chk("rr_timeout", ng, 8);
    drain();

    do_req(2, 1'b0, 4'b1011, 4'b1110, 1);
    drain();
    do_req(1, 1'b1, 4'b1110, 4'b1011, 3);
    drain();

    for (int v = 0; v < 16; v++) begin
      do_req(0, 1'b0, N'(v), b2g(N'(v)), 1);
      g = result;
      do_req(0, 1'b1, g, N'(v), 3);
    end
    drain();

    // Request arriving while a Gray->binary op is in flight.
    req[0] = 1'b1;
    mode[0] = 1'b1;
    data_in[0 +: N] = 4'b0110;
    gq.push_back(0);
    e.id = 0;
    e.res = 4'b0100;
    sb_q.push_back(e);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt[0]) begin ok = 1; break; end
    end
    if (!ok) chk("busy_gnt0_timeout", 0, 1);
    req[0] = 1'b0;
    @(negedge clk);
    chk("busy_cycle2", busy, 1);
    req[3] = 1'b1;
    mode[3] = 1'b0;
    data_in[3*N +: N] = 4'b0101;
    gq.push_back(3);
    e.id = 3;
    e.res = b2g(4'b0101);
    sb_q.push_back(e);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done[0]) begin ok = 1; break; end
      chk("no_gnt_busy", gnt, 0);
    end
    if (!ok) chk("busy_done0_timeout", 0, 1);
    @(negedge clk);
    chk("gnt3_after_done", gnt, 4'b1000);
    req[3] = 1'b0;
    drain();

    // Reset in the middle of a conversion.
    req[2] = 1'b1;
    mode[2] = 1'b1;
    data_in[2*N +: N] = 4'b1001;
    gq.push_back(2);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt[2]) begin ok = 1; break; end
    end
    if (!ok) chk("rst_gnt2_timeout", 0, 1);
    req[2] = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_result_id", result_id, 0);
    sb_q.delete();
    gq.delete();
    req = 4'hF;
    mode = 4'h0;
    data_in = '0;
    data_in[0 +: N] = 4'b1100;
    gq.push_back(0);
    e.id = 0;
    e.res = 4'b1010;
    sb_q.push_back(e);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt != '0) begin ok = 1; break; end
    end
    if (!ok) chk("post_rst_gnt_timeout", 0, 1);
    else chk("post_rst_first_gnt", gnt, 4'b0001);
    req = '0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_conv_scheduler.md
# gray_conv_scheduler

Round-robin scheduler that shares one binary/Gray conversion engine between R requesters. Each requester presents a binary or Gray operand with a mode bit. The block grants one requester at a time, performs the conversion, and returns the result tagged with the requester index. Binary→Gray takes one cycle. Gray→binary is resolved bit-serially over N-1 cycles. It sits between client logic (pointer/counter blocks) and the shared conversion datapath.

## Interface
- N, default 4: operand/result width in bits; legal range 2..16.
- R, default 4: number of requesters; power of two, legal range 2..8.
- IW, derived as log2(R): width of the requester index.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  R  per-requester request level; requester holds req, mode and its data slice stable until its gnt bit is seen.
- mode  in  R  per-requester operation; 0 = binary→Gray, 1 = Gray→binary.
- data_in  in  R*N  operands; requester k uses bits [k*N+N-1 : k*N].
- gnt  out  R  registered one-hot pulse, high for one cycle, when that requester's operand is captured.
- done  out  R  registered one-hot pulse, high for one cycle, when that requester's result is on result.
- result  out  N  conversion result; valid while done is high; holds its value until the next done.
- result_id  out  IW  index of the requester that owns result; changes together with result.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, CONV.
- IDLE, req ≠ 0 at an edge:
  - Select the winner by round-robin, starting the search at (last+1) mod R.
  - Capture the winner's operand, mode and index.
  - Set gnt to the winner's one-hot; set last to the winner; clear cnt; go to CONV.
- IDLE, req = 0: stay in IDLE; gnt = 0.
- CONV, mode 0: at the first edge, result ← op ^ (op >> 1); done ← onehot(id); result_id ← id; go to IDLE.
- CONV, mode 1: a working register w is initialised at capture with w[N-1] = g[N-1].
  - Each CONV edge resolves the next lower bit: w[i] = w[i+1] ^ g[i], MSB-1 down to 0.
  - cnt increments on each CONV edge.
  - On the edge that resolves bit 0 (cnt = N-2), load result from w, pulse done, and go to IDLE.
- In CONV, req is ignored; pending requests wait and are not lost.
- A requester whose req is still high in IDLE after its done is treated as a new request.
- The round-robin pointer last resets to R-1, so requester 0 has the highest priority after reset.
- Arithmetic is pure XOR on N bits; there is no overflow. Width and index are fixed by the parameters.

## Timing
- Reset (asynchronous, immediate): state = IDLE, gnt = 0, done = 0, busy = 0, result = 0, result_id = 0, last = R-1, cnt = 0.
- Reset mid-CONV discards the in-flight operation; no done is issued for it.
- Let E0 be the capture edge:
  - gnt and busy are high in the cycle after E0.
  - Binary→Gray: done is high in the cycle after E1.
  - Gray→binary: done is high in the cycle after E(N-1); for N = 4, three CONV edges.
- busy falls in the same cycle that done is high, because the state is already IDLE.
- The next capture can occur at the edge ending the done cycle. Binary→Gray throughput is one operation per 2 cycles.
- gnt and done are never high in the same cycle for the same requester.
- At most one gnt bit and one done bit are high at any time.

## Test plan
- Binary→Gray single (N=4, R=4): req[2]=1, mode[2]=0, slice 2 = 1011 → gnt=0100 for one cycle; next cycle done=0100, result=1110, result_id=2.
- Gray→binary single: req[1]=1, mode[1]=1, slice 1 = 1110 → gnt=0010; busy high for 3 CONV cycles; done=0010, result=1011, result_id=1.
- Round-robin fairness: req=1111 held continuously, slice k = k, mode=0 → grant order 0,1,2,3,0,…; results 0000, 0001, 0011, 0010 with matching result_id.
- Exhaustive round trip: via requester 0, convert every value 0..15 binary→Gray, then feed the result back Gray→binary → final result equals the original value for all 16.
- Request during busy: raise req[3] in the second CONV cycle of a Gray→binary operation for requester 0 → no gnt until IDLE; gnt=1000 exactly one cycle after requester 0's done.
- Reset mid-operation: drop rst_n during CONV → gnt, done, busy, result and result_id read 0 immediately; no done after release; with req=1111 the first grant is requester 0.
